// File: rtl/kypd_key_entry_if.sv
// Keypad entry bus: decoder-side inputs and debounced key/entry outputs.
// The master drives the decoder signals and the slave drives the results.
interface kypd_key_entry_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int NW = $clog2(NUM_DIGITS + 1);

  logic [3:0]    key_code;
  logic          key_pressed;
  logic          key_valid;
  logic [3:0]    key_out;
  logic [DW-1:0] entry;
  logic [NW-1:0] digit_count;
  logic          entry_full;
  logic [DW-1:0] value_out;
  logic          value_valid;

  modport master (
    output key_code, key_pressed,
    input  key_valid, key_out, entry, digit_count,
    input  entry_full, value_out, value_valid
  );

  modport slave (
    input  key_code, key_pressed,
    output key_valid, key_out, entry, digit_count,
    output entry_full, value_out, value_valid
  );
endinterface

// File: rtl/kypd_key_entry.sv
// Debounces the keypad decoder output into single press events and
// assembles them into a hex entry with backspace and enter.
module kypd_key_entry #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic clk,
  input  logic rst,
  kypd_key_entry_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int NW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NW-1:0] NFULL = NW'(NUM_DIGITS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [4:0]    sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;
  logic          kv_q, kv_d;
  logic [3:0]    kout_q, kout_d;
  logic [DW-1:0] entry_q, entry_d;
  logic [NW-1:0] count_q, count_d;
  logic [DW-1:0] value_q, value_d;
  logic          vv_q, vv_d;

  logic stable;
  logic accept;
  logic full;
  logic is_dig, is_bs, is_ent;
  logic [3:0] code;

  assign stable = (cnt_q == CMAX);
  assign code   = sample_q[3:0];
  assign full   = (count_q == NFULL);
  assign accept = (state_q == IDLE) && stable && sample_q[4];
  assign is_dig = (code <= 4'hD);
  assign is_bs  = (code == 4'hE);
  assign is_ent = (code == 4'hF);

  always_comb begin
    sample_d = {bus.key_pressed, bus.key_code};
    cnt_d    = cnt_q;
    state_d  = state_q;
    kv_d     = accept;
    kout_d   = kout_q;
    entry_d  = entry_q;
    count_d  = count_q;
    value_d  = value_q;
    vv_d     = 1'b0;

    if (sample_d != sample_q) begin
      cnt_d = '0;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Release must also be debounced before a new press is accepted.
    if (accept) begin
      state_d = HELD;
    end else if (state_q == HELD && stable && !sample_q[4]) begin
      state_d = IDLE;
    end

    if (accept) begin
      kout_d = code;
      unique case (1'b1)
        is_dig: begin
          if (!full) begin
            entry_d = (entry_q << 4) | DW'(code);
            count_d = count_q + NW'(1);
          end
        end
        is_bs: begin
          if (count_q != '0) begin
            entry_d = entry_q >> 4;
            count_d = count_q - NW'(1);
          end
        end
        is_ent: begin
          if (count_q != '0) begin
            value_d = entry_q;
            vv_d    = 1'b1;
            entry_d = '0;
            count_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      kv_q     <= 1'b0;
      kout_q   <= '0;
      entry_q  <= '0;
      count_q  <= '0;
      value_q  <= '0;
      vv_q     <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      kv_q     <= kv_d;
      kout_q   <= kout_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      value_q  <= value_d;
      vv_q     <= vv_d;
    end
  end

  assign bus.key_valid   = kv_q;
  assign bus.key_out     = kout_q;
  assign bus.entry       = entry_q;
  assign bus.digit_count = count_q;
  assign bus.entry_full  = full;
  assign bus.value_out   = value_q;
  assign bus.value_valid = vv_q;
endmodule

// File: tb/tb_kypd_key_entry.sv
// Self-checking bench for kypd_key_entry with a short debounce window.
// Expected key events are queued when a press is driven and checked on key_valid.
module tb_kypd_key_entry;
  localparam int DEB = 8;
  localparam int ND  = 4;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        full;
    logic [15:0] value;
    logic        vv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kypd_key_entry_if #(.NUM_DIGITS(ND)) bus ();

  kypd_key_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_DIGITS(ND)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   ev_cnt = 0;
  int   vv_cnt = 0;
  vec_t sb[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every key_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.value_valid) vv_cnt++;
    if (bus.key_valid) begin
      vec_t e;
      ev_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_key_valid: got key 0x%0h expected none",
                 bus.key_out);
      end else begin
        e = sb.pop_front();
        chk("key_out", 32'(bus.key_out), 32'(e.code));
        chk("entry", 32'(bus.entry), 32'(e.entry));
        chk("digit_count", 32'(bus.digit_count), 32'(e.cnt));
        chk("entry_full", 32'(bus.entry_full), 32'(e.full));
        chk("value_out", 32'(bus.value_out), 32'(e.value));
        chk("value_valid", 32'(bus.value_valid), 32'(e.vv));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.key_pressed = 1'b0;
    bus.key_code = 4'h0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] c, input int hold);
    bus.key_code = c;
    bus.key_pressed = 1'b1;
    cyc(hold);
    bus.key_pressed = 1'b0;
    cyc(12);
  endtask

  task automatic first_pulse(output int edge_no);
    edge_no = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.key_valid && edge_no == 0) edge_no = i;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_key_valid"}, 32'(bus.key_valid), 0);
    chk({tag, "_key_out"}, 32'(bus.key_out), 0);
    chk({tag, "_entry"}, 32'(bus.entry), 0);
    chk({tag, "_count"}, 32'(bus.digit_count), 0);
    chk({tag, "_full"}, 32'(bus.entry_full), 0);
    chk({tag, "_value"}, 32'(bus.value_out), 0);
    chk({tag, "_vv"}, 32'(bus.value_valid), 0);
  endtask

  vec_t tab[7];
  int   e0, v0, edge_no;

  initial begin
    tab[0] = '{4'h1, 16'h0001, 3'd1, 1'b0, 16'h0000, 1'b0};
    tab[1] = '{4'h2, 16'h0012, 3'd2, 1'b0, 16'h0000, 1'b0};
    tab[2] = '{4'h3, 16'h0123, 3'd3, 1'b0, 16'h0000, 1'b0};
    tab[3] = '{4'h4, 16'h1234, 3'd4, 1'b1, 16'h0000, 1'b0};
    tab[4] = '{4'h5, 16'h1234, 3'd4, 1'b1, 16'h0000, 1'b0};
    tab[5] = '{4'hE, 16'h0123, 3'd3, 1'b0, 16'h0000, 1'b0};
    tab[6] = '{4'hF, 16'h0000, 3'd0, 1'b0, 16'h0123, 1'b1};

    bus.key_code = 4'h0;
    bus.key_pressed = 1'b0;
    do_reset();
    chk_zero("reset");

    // 1: clean press, pulse on the 9th edge
    e0 = ev_cnt;
    sb.push_back('{4'h5, 16'h0005, 3'd1, 1'b0, 16'h0000, 1'b0});
    bus.key_code = 4'h5;
    bus.key_pressed = 1'b1;
    first_pulse(edge_no);
    chk("t1_latency", 32'(edge_no), 9);
    bus.key_pressed = 1'b0;
    cyc(12);
    chk("t1_events", 32'(ev_cnt - e0), 1);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // 2: bouncing press
    do_reset();
    e0 = ev_cnt;
    bus.key_code = 4'h1;
    for (int i = 0; i < 10; i++) begin
      bus.key_pressed = ~bus.key_pressed;
      cyc(3);
    end
    bus.key_pressed = 1'b0;
    cyc(1);
    chk("t2_no_bounce_event", 32'(ev_cnt - e0), 0);
    sb.push_back('{4'h1, 16'h0001, 3'd1, 1'b0, 16'h0000, 1'b0});
    bus.key_pressed = 1'b1;
    first_pulse(edge_no);
    chk("t2_latency", 32'(edge_no), 9);
    bus.key_pressed = 1'b0;
    cyc(12);
    chk("t2_events", 32'(ev_cnt - e0), 1);

    // 3: table of digits, overflow, backspace, enter
    do_reset();
    e0 = ev_cnt;
    v0 = vv_cnt;
    foreach (tab[i]) begin
      sb.push_back(tab[i]);
      press(tab[i].code, 12);
    end
    chk("t3_events", 32'(ev_cnt - e0), 7);
    chk("t3_vv_pulses", 32'(vv_cnt - v0), 1);
    chk("t3_value_held", 32'(bus.value_out), 32'h0123);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // 4: code change while held yields no event
    do_reset();
    e0 = ev_cnt;
    sb.push_back('{4'h7, 16'h0007, 3'd1, 1'b0, 16'h0000, 1'b0});
    bus.key_code = 4'h7;
    bus.key_pressed = 1'b1;
    cyc(500);
    bus.key_code = 4'h8;
    cyc(500);
    bus.key_pressed = 1'b0;
    cyc(12);
    chk("t4_one_event", 32'(ev_cnt - e0), 1);
    sb.push_back('{4'h8, 16'h0078, 3'd2, 1'b0, 16'h0000, 1'b0});
    press(4'h8, 12);
    chk("t4_two_events", 32'(ev_cnt - e0), 2);

    // 5: reset while held re-debounces the key
    do_reset();
    e0 = ev_cnt;
    sb.push_back('{4'h3, 16'h0003, 3'd1, 1'b0, 16'h0000, 1'b0});
    bus.key_code = 4'h3;
    bus.key_pressed = 1'b1;
    cyc(15);
    rst = 1'b1;
    cyc(1);
    chk_zero("t5_rst");
    rst = 1'b0;
    sb.push_back('{4'h3, 16'h0003, 3'd1, 1'b0, 16'h0000, 1'b0});
    first_pulse(edge_no);
    chk("t5_latency", 32'(edge_no), 9);
    bus.key_pressed = 1'b0;
    cyc(12);
    chk("t5_events", 32'(ev_cnt - e0), 2);

    // 6: backspace and enter on empty entry
    do_reset();
    e0 = ev_cnt;
    v0 = vv_cnt;
    sb.push_back('{4'hE, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0});
    press(4'hE, 12);
    sb.push_back('{4'hF, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0});
    press(4'hF, 12);
    chk("t6_events", 32'(ev_cnt - e0), 2);
    chk("t6_no_vv", 32'(vv_cnt - v0), 0);
    chk("t6_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
